pipe_hazard_unit: RTL and testbench

Hazard and forwarding controller for the 5-stage pipelined MIPS datapath (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers for the EX, MEM and WB stages in its own shadow pipeline.
- Drives forwarding selects for both ALU operands.
- Detects load-use hazards and inserts bubbles.
- Flushes IF/ID on taken branches and jumps.
- Keeps saturating stall and flush statistics counters.

---
 rtl/pipe_hazard_unit_if.sv | 36 +++
 rtl/pipe_hazard_unit.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_if.sv
// rtl/pipe_hazard_unit_if.sv - ID-stage request and hazard-control bundle for pipe_hazard_unit
interface pipe_hazard_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rs;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] id_dest;
   logic                  id_regwrite;
   logic                  id_memread;
   logic                  id_jump;
   logic                  ex_branch_taken;

   logic                  stall;
   logic                  flush_if;
   logic                  flush_id;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic [CNT_W-1:0]      stall_count;
   logic [CNT_W-1:0]      flush_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_regwrite, id_memread, id_jump, ex_branch_taken,
      input  stall, flush_if, flush_id, fwd_a, fwd_b, stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_regwrite, id_memread, id_jump, ex_branch_taken,
      output stall, flush_if, flush_id, fwd_a, fwd_b, stall_count, flush_count
   );
endinterface

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use stall, branch/jump flush and ALU forwarding control for a 5-stage MIPS pipe
module pipe_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_unit_if.slave  hz
);

   logic                  ex_valid_q,    ex_valid_d;
   logic [REG_ADDR_W-1:0] ex_rs_q,       ex_rs_d;
   logic [REG_ADDR_W-1:0] ex_rt_q,       ex_rt_d;
   logic                  ex_uses_rs_q,  ex_uses_rs_d;
   logic                  ex_uses_rt_q,  ex_uses_rt_d;
   logic [REG_ADDR_W-1:0] ex_dest_q,     ex_dest_d;
   logic                  ex_regwrite_q, ex_regwrite_d;
   logic                  ex_memread_q,  ex_memread_d;

   logic                  mem_valid_q,    mem_valid_d;
   logic [REG_ADDR_W-1:0] mem_dest_q,     mem_dest_d;
   logic                  mem_regwrite_q, mem_regwrite_d;

   logic                  wb_valid_q,    wb_valid_d;
   logic [REG_ADDR_W-1:0] wb_dest_q,     wb_dest_d;
   logic                  wb_regwrite_q, wb_regwrite_d;

   logic [CNT_W-1:0]      stall_count_q, stall_count_d;
   logic [CNT_W-1:0]      flush_count_q, flush_count_d;

   logic                  load_use;
   logic                  stall;
   logic                  flush_id;
   logic                  flush_if;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;

   // MEM producer wins over WB: it is the younger write to the same register.
   function automatic logic [1:0] fwd_sel(
      input logic                  ex_valid,
      input logic                  uses_src,
      input logic [REG_ADDR_W-1:0] src,
      input logic                  mem_valid,
      input logic                  mem_regwrite,
      input logic [REG_ADDR_W-1:0] mem_dest,
      input logic                  wb_valid,
      input logic                  wb_regwrite,
      input logic [REG_ADDR_W-1:0] wb_dest
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_valid && uses_src) begin
         if (mem_valid && mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
            sel = 2'b10;
         end else if (wb_valid && wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   always_comb begin
      load_use = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_dest_q != '0) &&
                 hz.id_valid &&
                 ((hz.id_uses_rs && (hz.id_rs == ex_dest_q)) ||
                  (hz.id_uses_rt && (hz.id_rt == ex_dest_q)));
      stall    = load_use && !hz.ex_branch_taken;
      flush_if = hz.ex_branch_taken;
      flush_id = hz.ex_branch_taken || (hz.id_jump && hz.id_valid && !stall);
      fwd_a    = fwd_sel(ex_valid_q, ex_uses_rs_q, ex_rs_q,
                         mem_valid_q, mem_regwrite_q, mem_dest_q,
                         wb_valid_q, wb_regwrite_q, wb_dest_q);
      fwd_b    = fwd_sel(ex_valid_q, ex_uses_rt_q, ex_rt_q,
                         mem_valid_q, mem_regwrite_q, mem_dest_q,
                         wb_valid_q, wb_regwrite_q, wb_dest_q);
   end

   always_comb begin
      // Fields always follow ID; only the valid bit decides whether EX holds a bubble.
      ex_valid_d     = hz.id_valid && !stall && !hz.ex_branch_taken;
      ex_rs_d        = hz.id_rs;
      ex_rt_d        = hz.id_rt;
      ex_uses_rs_d   = hz.id_uses_rs;
      ex_uses_rt_d   = hz.id_uses_rt;
      ex_dest_d      = hz.id_dest;
      ex_regwrite_d  = hz.id_regwrite;
      ex_memread_d   = hz.id_memread;

      mem_valid_d    = ex_valid_q;
      mem_dest_d     = ex_dest_q;
      mem_regwrite_d = ex_regwrite_q;

      wb_valid_d     = mem_valid_q;
      wb_dest_d      = mem_dest_q;
      wb_regwrite_d  = mem_regwrite_q;

      stall_count_d  = stall_count_q;
      flush_count_d  = flush_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
      if (flush_id && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_uses_rs_q   <= 1'b0;
         ex_uses_rt_q   <= 1'b0;
         ex_dest_q      <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_dest_q     <= '0;
         mem_regwrite_q <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_dest_q      <= '0;
         wb_regwrite_q  <= 1'b0;
         stall_count_q  <= '0;
         flush_count_q  <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_uses_rs_q   <= ex_uses_rs_d;
         ex_uses_rt_q   <= ex_uses_rt_d;
         ex_dest_q      <= ex_dest_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         mem_valid_q    <= mem_valid_d;
         mem_dest_q     <= mem_dest_d;
         mem_regwrite_q <= mem_regwrite_d;
         wb_valid_q     <= wb_valid_d;
         wb_dest_q      <= wb_dest_d;
         wb_regwrite_q  <= wb_regwrite_d;
         stall_count_q  <= stall_count_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign hz.stall       = stall;
   assign hz.flush_if    = flush_if;
   assign hz.flush_id    = flush_id;
   assign hz.fwd_a       = fwd_a;
   assign hz.fwd_b       = fwd_b;
   assign hz.stall_count = stall_count_q;
   assign hz.flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit against an instruction-history model
module tb_pipe_hazard_unit;
   localparam int AW = 5;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();
   pipe_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          urs;
      logic          urt;
      logic [AW-1:0] dest;
      logic          rw;
      logic          mr;
   } ins_t;

   typedef struct packed {
      logic          stall;
      logic          fif;
      logic          fid;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t exp_q[$];
   ins_t hist[$];   // instructions in entry order: [2] now in EX, [1] in MEM, [0] in WB
   int   sc_m, fc_m;
   int   total = 0;
   int   bad   = 0;
   logic st, fid;

   function automatic ins_t rtype(input int rd, input int rs, input int rt);
      ins_t i = '0;
      i.v = 1; i.rs = AW'(rs); i.rt = AW'(rt); i.urs = 1; i.urt = 1; i.dest = AW'(rd); i.rw = 1;
      return i;
   endfunction

   function automatic ins_t itype(input int rt, input int rs);
      ins_t i = '0;
      i.v = 1; i.rs = AW'(rs); i.rt = AW'(rt); i.urs = 1; i.dest = AW'(rt); i.rw = 1;
      return i;
   endfunction

   function automatic ins_t lw(input int rt, input int base);
      ins_t i = itype(rt, base);
      i.mr = 1;
      return i;
   endfunction

   function automatic ins_t nop();
      ins_t i = '0;
      i.v = 1;
      return i;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] src, input logic u);
      ins_t ex = hist[2];
      if (!ex.v || !u) return 2'b00;
      for (int age = 1; age <= 2; age++) begin
         ins_t p = hist[2 - age];
         if (p.v && p.rw && p.dest != 0 && p.dest == src) return (age == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back('0);
      sc_m = 0;
      fc_m = 0;
   endtask

   task automatic step(input ins_t id, input logic jmp, input logic br, input logic rst,
                       output logic o_st, output logic o_fid);
      ins_t ex;
      ins_t nxt;
      exp_t e;
      logic haz;
      hz.id_valid        = id.v;
      hz.id_rs           = id.rs;
      hz.id_rt           = id.rt;
      hz.id_uses_rs      = id.urs;
      hz.id_uses_rt      = id.urt;
      hz.id_dest         = id.dest;
      hz.id_regwrite     = id.rw;
      hz.id_memread      = id.mr;
      hz.id_jump         = jmp;
      hz.ex_branch_taken = br;
      reset              = rst;

      ex  = hist[2];
      haz = ex.v && ex.mr && ex.rw && ex.dest != 0 && id.v &&
            ((id.urs && id.rs == ex.dest) || (id.urt && id.rt == ex.dest));
      o_st  = haz && !br;
      o_fid = br || (jmp && id.v && !o_st);
      e.stall = o_st;
      e.fif   = br;
      e.fid   = o_fid;
      e.fa    = m_fwd(ex.rs, ex.urs);
      e.fb    = m_fwd(ex.rt, ex.urt);
      e.sc    = CW'(sc_m);
      e.fc    = CW'(fc_m);
      exp_q.push_back(e);

      if (rst) begin
         model_reset();
      end else begin
         if (o_st  && sc_m < (1 << CW) - 1) sc_m++;
         if (o_fid && fc_m < (1 << CW) - 1) fc_m++;
         nxt = (o_st || br) ? ins_t'(0) : id;
         hist.push_back(nxt);
         void'(hist.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall",       16'(hz.stall),       16'(e.stall));
         chk("flush_if",    16'(hz.flush_if),    16'(e.fif));
         chk("flush_id",    16'(hz.flush_id),    16'(e.fid));
         chk("fwd_a",       16'(hz.fwd_a),       16'(e.fa));
         chk("fwd_b",       16'(hz.fwd_b),       16'(e.fb));
         chk("stall_count", 16'(hz.stall_count), 16'(e.sc));
         chk("flush_count", 16'(hz.flush_count), 16'(e.fc));
      end
   end

   task automatic nops(input int n);
      for (int k = 0; k < n; k++) step(nop(), 0, 0, 0, st, fid);
   endtask

   task automatic run_held(input ins_t i);
      step(i, 0, 0, 0, st, fid);
      for (int k = 0; k < 4 && st; k++) step(i, 0, 0, 0, st, fid);
   endtask

   initial begin
      ins_t cur;
      ins_t bub;
      logic prev_st, prev_fid, jmp, br, rst;
      bub = '0;

      reset = 1'b1;
      hz.id_valid = 0; hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
      hz.id_dest = 0; hz.id_regwrite = 0; hz.id_memread = 0; hz.id_jump = 0;
      hz.ex_branch_taken = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // back-to-back ALU dependency, then WB-distance and double-producer cases
      step(rtype(3, 1, 2), 0, 0, 0, st, fid);
      step(rtype(4, 3, 5), 0, 0, 0, st, fid);
      nops(3);
      step(rtype(3, 1, 2), 0, 0, 0, st, fid);
      step(nop(), 0, 0, 0, st, fid);
      step(rtype(6, 7, 3), 0, 0, 0, st, fid);
      nops(3);
      step(rtype(3, 1, 2), 0, 0, 0, st, fid);
      step(rtype(3, 4, 5), 0, 0, 0, st, fid);
      step(rtype(6, 3, 3), 0, 0, 0, st, fid);
      nops(3);

      // load-use, load to $0, and an immediate op whose rt matches the load
      step(lw(8, 1), 0, 0, 0, st, fid);
      run_held(rtype(9, 8, 8));
      nops(3);
      step(lw(0, 1), 0, 0, 0, st, fid);
      step(rtype(9, 0, 0), 0, 0, 0, st, fid);
      step(lw(8, 1), 0, 0, 0, st, fid);
      step(itype(8, 1), 0, 0, 0, st, fid);
      nops(3);

      // taken branch colliding with a load-use hazard, then a jump
      step(lw(8, 1), 0, 0, 0, st, fid);
      step(rtype(9, 8, 8), 0, 1, 0, st, fid);
      step(bub, 0, 0, 0, st, fid);
      step(nop(), 1, 0, 0, st, fid);
      step(bub, 0, 0, 0, st, fid);
      nops(2);

      // stall counter saturation, then reset while a stall is active
      step(nop(), 0, 0, 1, st, fid);
      for (int k = 0; k < (1 << CW) + 5; k++) begin
         step(lw(8, 1), 0, 0, 0, st, fid);
         run_held(rtype(9, 8, 8));
      end
      step(lw(8, 1), 0, 0, 0, st, fid);
      step(rtype(9, 8, 8), 0, 0, 1, st, fid);
      step(rtype(9, 8, 8), 0, 0, 0, st, fid);
      nops(2);
      step(nop(), 0, 0, 1, st, fid);

      // randomized traffic over a small register set to provoke hazards
      prev_st = 0;
      prev_fid = 0;
      cur = nop();
      for (int n = 0; n < 3000; n++) begin
         if (!prev_st) begin
            if (prev_fid) begin
               cur = bub;
            end else begin
               cur.v    = ($urandom_range(0, 7) != 0);
               cur.rs   = AW'($urandom_range(0, 3));
               cur.rt   = AW'($urandom_range(0, 3));
               cur.urs  = $urandom_range(0, 3) != 0;
               cur.urt  = $urandom_range(0, 1) != 0;
               cur.dest = AW'($urandom_range(0, 3));
               cur.mr   = ($urandom_range(0, 2) == 0);
               cur.rw   = cur.mr || ($urandom_range(0, 3) != 0);
            end
         end
         jmp = ($urandom_range(0, 9) == 0);
         br  = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step(cur, jmp, br, rst, st, fid);
         prev_st  = st;
         prev_fid = fid;
      end

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
